// File: rtl/multiplier_result_checker.sv
// ---------------------------------------------------------------------------
// multiplier_result_checker
//
// Scores a combinational multiplier under test. Each {A, B, P} triple that
// the checker accepts is registered into a single pipeline stage. On the
// following edge the product A*B is recomputed at full width, and the result
// is compared with the P that the multiplier under test returned. The block
// counts the vectors it compared and the mismatches it found, and it keeps
// the first failing triple for later inspection.
//
// Parameters
//   WIDTH            operand width; the product is 2*WIDTH bits
//   CNT_W            width of num_tests, tested_count and err_count
//
// Ports
//   clk              rising-edge clock
//   rst_n            asynchronous active-low reset
//   start            begins a run; honoured only in IDLE or DONE
//   num_tests        number of vectors in the run, sampled on start
//   in_valid         a_in/b_in/p_in carry a vector
//   in_ready         the checker takes a vector this cycle
//   a_in, b_in       operands that were applied to the multiplier
//   p_in             product that the multiplier returned
//   busy             a run is in progress (RUN or DRAIN)
//   done             the run is finished and the results are stable
//   pass             done with no mismatches
//   tested_count     vectors compared so far
//   err_count        mismatches so far, saturating at all-ones
//   first_err_valid  a mismatch has been captured
//   first_err_a/b/p  the triple of the first mismatch
// ---------------------------------------------------------------------------
module multiplier_result_checker #(
    parameter int WIDTH = 2,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [CNT_W-1:0]     num_tests,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a_in,
    input  logic [WIDTH-1:0]     b_in,
    input  logic [2*WIDTH-1:0]   p_in,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CNT_W-1:0]     tested_count,
    output logic [CNT_W-1:0]     err_count,
    output logic                 first_err_valid,
    output logic [WIDTH-1:0]     first_err_a,
    output logic [WIDTH-1:0]     first_err_b,
    output logic [2*WIDTH-1:0]   first_err_p
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [CNT_W-1:0]   num_tests_q;
    logic [CNT_W-1:0]   accepted_count;

    logic               s1_valid;
    logic [WIDTH-1:0]   s1_a;
    logic [WIDTH-1:0]   s1_b;
    logic [2*WIDTH-1:0] s1_p;
    logic [2*WIDTH-1:0] s1_expected;
    logic               s1_mismatch;

    logic               start_ok;
    logic               transfer;
    logic               last_accept;

    // A start pulse takes effect only while no run is in flight.
    assign start_ok = start && ((state == ST_IDLE) || (state == ST_DONE));

    assign transfer = in_valid && in_ready;

    // The comparison is made one bit wider, so that the final acceptance
    // is still detected when num_tests is all-ones.
    assign last_accept = transfer &&
        (({1'b0, accepted_count} + {{CNT_W{1'b0}}, 1'b1}) ==
         {1'b0, num_tests_q});

    // Both operands are zero-extended before the multiply. The reference
    // product is then the full 2*WIDTH-bit unsigned result, with no
    // truncation.
    assign s1_expected = {{WIDTH{1'b0}}, s1_a} * {{WIDTH{1'b0}}, s1_b};
    assign s1_mismatch = s1_valid && (s1_p != s1_expected);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. DRAIN waits until the stage-1 register is empty,
    // so that the last accepted vector has been scored before DONE.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_next = (num_tests != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (last_accept) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!s1_valid) begin
                    state_next = ST_DONE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Output decode. in_ready depends only on registered state, not on
    // in_valid, so the sender sees no combinational loop.
    always_comb begin
        in_ready = (state == ST_RUN) && (accepted_count < num_tests_q);
        busy     = (state == ST_RUN) || (state == ST_DRAIN);
        done     = (state == ST_DONE);
        pass     = (state == ST_DONE) && (err_count == '0);
    end

    // Run length and acceptance bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_tests_q    <= '0;
            accepted_count <= '0;
        end else if (start_ok) begin
            num_tests_q    <= num_tests;
            accepted_count <= '0;
        end else if (transfer) begin
            accepted_count <= accepted_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Stage-1 register. It holds the accepted triple for exactly one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_p     <= '0;
        end else begin
            s1_valid <= transfer;
            if (transfer) begin
                s1_a <= a_in;
                s1_b <= b_in;
                s1_p <= p_in;
            end
        end
    end

    // Scoring. The counters and the first-error capture update one edge
    // after acceptance. The error count holds at all-ones rather than
    // wrapping back to a value that would look like a pass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tested_count    <= '0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_a     <= '0;
            first_err_b     <= '0;
            first_err_p     <= '0;
        end else if (start_ok) begin
            tested_count    <= '0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_a     <= '0;
            first_err_b     <= '0;
            first_err_p     <= '0;
        end else if (s1_valid) begin
            tested_count <= tested_count + {{(CNT_W-1){1'b0}}, 1'b1};
            if (s1_mismatch) begin
                if (err_count != {CNT_W{1'b1}}) begin
                    err_count <= err_count + {{(CNT_W-1){1'b0}}, 1'b1};
                end
                if (!first_err_valid) begin
                    first_err_valid <= 1'b1;
                    first_err_a     <= s1_a;
                    first_err_b     <= s1_b;
                    first_err_p     <= s1_p;
                end
            end
        end
    end

endmodule

// File: tb/tb_multiplier_result_checker.sv
// ---------------------------------------------------------------------------
// tb_multiplier_result_checker
//
// Self-checking bench for multiplier_result_checker with WIDTH=2, CNT_W=16.
// A transaction-level model follows the run. It holds the number of vectors
// still to accept, a queue of vectors that are waiting to be scored, and
// the scores themselves. A compare process checks every DUT output against
// this model on each falling edge. Directed scenarios add hand-computed
// literal expectations. Randomized runs follow them.
// ---------------------------------------------------------------------------
module tb_multiplier_result_checker;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] num_tests;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  a_in;
    logic [1:0]  b_in;
    logic [3:0]  p_in;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] tested_count;
    logic [15:0] err_count;
    logic        first_err_valid;
    logic [1:0]  first_err_a;
    logic [1:0]  first_err_b;
    logic [3:0]  first_err_p;

    int total_checks = 0;
    int bad_checks   = 0;

    multiplier_result_checker #(.WIDTH(2), .CNT_W(16)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .num_tests       (num_tests),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .a_in            (a_in),
        .b_in            (b_in),
        .p_in            (p_in),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .tested_count    (tested_count),
        .err_count       (err_count),
        .first_err_valid (first_err_valid),
        .first_err_a     (first_err_a),
        .first_err_b     (first_err_b),
        .first_err_p     (first_err_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef struct {
        int a;
        int b;
        int p;
    } vec_t;

    vec_t pipe[$];
    bit   m_started = 0;
    bit   m_open    = 0;
    int   m_left    = 0;
    int   m_tested  = 0;
    int   m_err     = 0;
    bit   m_fv      = 0;
    int   m_fa      = 0;
    int   m_fb      = 0;
    int   m_fp      = 0;

    bit   mdl_rdy;
    bit   mdl_was_empty;
    int   mdl_left_before;
    vec_t mdl_v;

    always @(posedge clk) begin
        if (!rst_n) begin
            pipe.delete();
            m_started = 0; m_open = 0; m_left = 0;
            m_tested = 0; m_err = 0; m_fv = 0;
            m_fa = 0; m_fb = 0; m_fp = 0;
        end else begin
            mdl_rdy         = m_open && (m_left > 0);
            mdl_was_empty   = (pipe.size() == 0);
            mdl_left_before = m_left;
            if (start && !m_open) begin
                m_started = 1;
                m_left    = int'(num_tests);
                m_open    = (num_tests != 16'd0);
                pipe.delete();
                m_tested = 0; m_err = 0; m_fv = 0;
                m_fa = 0; m_fb = 0; m_fp = 0;
            end else begin
                while (pipe.size() > 0) begin
                    mdl_v = pipe.pop_front();
                    m_tested++;
                    if (mdl_v.p != mdl_v.a * mdl_v.b) begin
                        if (m_err < 65535) m_err++;
                        if (!m_fv) begin
                            m_fv = 1;
                            m_fa = mdl_v.a; m_fb = mdl_v.b; m_fp = mdl_v.p;
                        end
                    end
                end
                if (mdl_rdy && in_valid) begin
                    mdl_v.a = int'(a_in);
                    mdl_v.b = int'(b_in);
                    mdl_v.p = int'(p_in);
                    pipe.push_back(mdl_v);
                    m_left--;
                end
                if (m_open && mdl_left_before == 0 && mdl_was_empty) m_open = 0;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        total_checks++;
        if (act !== exp) begin
            bad_checks++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        checkOutput("in_ready",  32'(in_ready),        32'(m_open && m_left > 0));
        checkOutput("busy",      32'(busy),            32'(m_open));
        checkOutput("done",      32'(done),            32'(m_started && !m_open));
        checkOutput("pass",      32'(pass),            32'(m_started && !m_open && m_err == 0));
        checkOutput("tested",    32'(tested_count),    32'(m_tested));
        checkOutput("err",       32'(err_count),       32'(m_err));
        checkOutput("fe_valid",  32'(first_err_valid), 32'(m_fv));
        checkOutput("fe_a",      32'(first_err_a),     32'(m_fa));
        checkOutput("fe_b",      32'(first_err_b),     32'(m_fb));
        checkOutput("fe_p",      32'(first_err_p),     32'(m_fp));
    end

    // ---------------- stimulus helpers ----------------
    task automatic doStart(input int n);
        start     = 1'b1;
        num_tests = 16'(n);
        @(negedge clk); #1;
        start     = 1'b0;
    endtask

    // Offers one vector and holds it until it is accepted (bounded wait).
    task automatic applyStimulus(input int a, input int b, input int p);
        bit got;
        got      = 1'b0;
        in_valid = 1'b1;
        a_in     = 2'(a);
        b_in     = 2'(b);
        p_in     = 4'(p);
        for (int i = 0; i < 50 && !got; i++) begin
            got = in_ready;
            @(negedge clk); #1;
        end
        checkOutput("accepted", 32'(got), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic waitDone();
        int i;
        i = 0;
        while (!done && i < 100) begin
            @(negedge clk); #1;
            i++;
        end
        checkOutput("wait_done", 32'(done), 32'd1);
    endtask

    // ---------------- directed and random scenarios ----------------
    initial begin
        logic [4:0] rdy_seen;
        int         xfers;
        int         n, av, bv, pv, gap;

        rst_n = 1'b0; start = 1'b0; num_tests = '0;
        in_valid = 1'b0; a_in = '0; b_in = '0; p_in = '0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        checkOutput("rst_tested", 32'(tested_count), 32'd0);
        checkOutput("rst_done",   32'(done),         32'd0);
        checkOutput("rst_ready",  32'(in_ready),     32'd0);

        // All four products are correct; valid is high every cycle.
        doStart(4);
        applyStimulus(1, 2, 2);
        applyStimulus(2, 3, 6);
        applyStimulus(3, 3, 9);
        applyStimulus(1, 1, 1);
        checkOutput("t1_done_e0", 32'(done), 32'd0);
        @(negedge clk); #1;
        checkOutput("t1_done_e1", 32'(done), 32'd0);
        @(negedge clk); #1;
        checkOutput("t1_done_e2", 32'(done),            32'd1);
        checkOutput("t1_tested",  32'(tested_count),    32'd4);
        checkOutput("t1_err",     32'(err_count),       32'd0);
        checkOutput("t1_pass",    32'(pass),            32'd1);
        checkOutput("t1_fv",      32'(first_err_valid), 32'd0);

        // Two mismatches. The first of them is captured.
        doStart(3);
        applyStimulus(1, 3, 3);
        applyStimulus(3, 3, 8);
        applyStimulus(2, 1, 3);
        waitDone();
        checkOutput("t2_err",    32'(err_count),    32'd2);
        checkOutput("t2_pass",   32'(pass),         32'd0);
        checkOutput("t2_fa",     32'(first_err_a),  32'd3);
        checkOutput("t2_fb",     32'(first_err_b),  32'd3);
        checkOutput("t2_fp",     32'(first_err_p),  32'd8);
        checkOutput("t2_tested", 32'(tested_count), 32'd3);

        // valid stays high for 5 cycles, but only 2 transfers may happen.
        doStart(2);
        in_valid = 1'b1; a_in = 2'd1; b_in = 2'd1; p_in = 4'd1;
        xfers = 0;
        for (int i = 0; i < 5; i++) begin
            rdy_seen[i] = in_ready;
            if (in_ready) xfers++;
            @(negedge clk); #1;
        end
        in_valid = 1'b0;
        checkOutput("t3_xfers", 32'(xfers),    32'd2);
        checkOutput("t3_ready", 32'(rdy_seen), 32'b00011);
        waitDone();
        checkOutput("t3_tested", 32'(tested_count), 32'd2);

        // An empty run finishes on the next edge.
        doStart(0);
        checkOutput("t4_done",   32'(done),         32'd1);
        checkOutput("t4_pass",   32'(pass),         32'd1);
        checkOutput("t4_tested", 32'(tested_count), 32'd0);

        // A start pulse during RUN is ignored.
        doStart(4);
        applyStimulus(1, 1, 1);
        doStart(9);
        applyStimulus(2, 2, 4);
        applyStimulus(3, 2, 6);
        applyStimulus(0, 3, 0);
        waitDone();
        checkOutput("t5_tested", 32'(tested_count), 32'd4);

        // Reset in the middle of a run, followed by a fresh one-vector run.
        doStart(4);
        applyStimulus(1, 2, 2);
        applyStimulus(3, 1, 5);
        rst_n = 1'b0;
        #1;
        checkOutput("t6_tested", 32'(tested_count),    32'd0);
        checkOutput("t6_err",    32'(err_count),       32'd0);
        checkOutput("t6_busy",   32'(busy),            32'd0);
        checkOutput("t6_done",   32'(done),            32'd0);
        checkOutput("t6_fv",     32'(first_err_valid), 32'd0);
        @(negedge clk); #1;
        rst_n = 1'b1;
        doStart(1);
        applyStimulus(2, 2, 4);
        waitDone();
        checkOutput("t6_pass",    32'(pass),         32'd1);
        checkOutput("t6_tested2", 32'(tested_count), 32'd1);

        // Randomized runs with gaps, stray start pulses, corrupted
        // products, and vectors offered while the checker is not ready.
        for (int r = 0; r < 12; r++) begin
            in_valid = 1'b1;
            a_in = 2'($urandom_range(0, 3)); b_in = 2'($urandom_range(0, 3));
            p_in = 4'($urandom_range(0, 15));
            repeat (2) begin @(negedge clk); #1; end
            in_valid = 1'b0;
            n = $urandom_range(1, 12);
            doStart(n);
            for (int k = 0; k < n; k++) begin
                gap = $urandom_range(0, 2);
                repeat (gap) begin @(negedge clk); #1; end
                if ($urandom_range(0, 7) == 0) doStart($urandom_range(0, 20));
                av = $urandom_range(0, 3);
                bv = $urandom_range(0, 3);
                pv = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : av * bv;
                applyStimulus(av, bv, pv);
            end
            waitDone();
        end

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
